// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests a word at pc, holds it for the branch unit, then advances pc.
// Optional HALT opcode support is enabled with macro HAP_HALT_EN.
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [7:0]  npc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [7:0]  br_pc,
  output logic [7:0]  pc,
  output logic        halted
);

  // state   | meaning
  // S_IDLE  | stopped, waiting for en
  // S_REQ   | imem_req high at pc, waiting for imem_ack
  // S_VALID | instr/npc presented, waiting for instr_ready
  // S_HALT  | HALT accepted, frozen until reset (HAP_HALT_EN only)
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID
`ifdef HAP_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic [15:0] instr_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic [4:0]  opcode;
  logic        is_branch;

  assign opcode    = instr_q[15:11];
  // BNE, BE, BNER, BER, J, JR occupy one contiguous opcode range
  assign is_branch = (opcode >= 5'b10011) && (opcode <= 5'b11000);
  assign npc       = pc_q + 8'd1;
  assign pc_d      = is_branch ? br_pc : npc;

`ifdef HAP_HALT_EN
  logic halted_q;
  logic is_halt;
  assign is_halt = (opcode == 5'b11111);
  assign halted  = halted_q;
`else
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef HAP_HALT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            state_q       <= S_VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_d;
`ifdef HAP_HALT_EN
            if (is_halt) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else
`endif
            if (en) begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
`ifdef HAP_HALT_EN
        S_HALT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table of fetch transactions plus reset and HALT sequences.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  npc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  br_pc;
  logic [7:0]  pc;
  logic        halted;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0]  exp_addr;
    logic [15:0] rdata;
    logic [7:0]  br;
    int          ack_lat;
    int          rdy_lat;
    logic        en_acc;
    logic [7:0]  exp_npc;
    logic [7:0]  exp_next;
  } vec_t;

  vec_t vecs[9];

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .npc         (npc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_pc       (br_pc),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          addr   rdata     br     ackl rdyl en    npc    next
    vecs[0] = '{8'h00, 16'h0800, 8'h00, 0,   0,   1'b1, 8'h01, 8'h01};
    vecs[1] = '{8'h01, 16'hB842, 8'h42, 1,   0,   1'b1, 8'h02, 8'h42};
    vecs[2] = '{8'h42, 16'h9800, 8'hFE, 0,   2,   1'b1, 8'h43, 8'hFE};
    vecs[3] = '{8'hFE, 16'hC000, 8'hFF, 2,   0,   1'b1, 8'hFF, 8'hFF};
    vecs[4] = '{8'hFF, 16'h0000, 8'h10, 0,   1,   1'b1, 8'h00, 8'h00};
    vecs[5] = '{8'h00, 16'h9000, 8'h77, 0,   0,   1'b0, 8'h01, 8'h01};
    vecs[6] = '{8'h01, 16'hC800, 8'h55, 3,   0,   1'b1, 8'h02, 8'h02};
    vecs[7] = '{8'h02, 16'h1234, 8'h99, 0,   5,   1'b1, 8'h03, 8'h03};
    vecs[8] = '{8'h03, 16'hF800, 8'h20, 0,   0,   1'b1, 8'h04, 8'h04};

    rst_n       = 1'b0;
    en          = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 16'hFFFF;
    instr_ready = 1'b1;
    br_pc       = 8'hAA;
    step();
    step();
    chk("rst_req",    imem_req,    1'b0);
    chk("rst_valid",  instr_valid, 1'b0);
    chk("rst_pc",     pc,          8'h00);
    chk("rst_npc",    npc,         8'h01);
    chk("rst_instr",  instr,       16'h0000);
    chk("rst_halted", halted,      1'b0);
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    rst_n       = 1'b1;

    for (int i = 0; i < 9; i++) begin
      int n;
      n = 0;
      if (i > 0 && vecs[i-1].en_acc) chk("b2b_req", imem_req, 1'b1);
      while (!imem_req && n < 10) begin
        step();
        n++;
      end
      chk("req_seen", imem_req, 1'b1);
      chk("req_addr", imem_addr, vecs[i].exp_addr);
      chk("valid_in_req", instr_valid, 1'b0);
      for (int k = 0; k < vecs[i].ack_lat; k++) begin
        step();
        chk("req_hold", imem_req, 1'b1);
        chk("addr_hold", imem_addr, vecs[i].exp_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = vecs[i].rdata;
      en         = vecs[i].en_acc;
      step();
      imem_rdata = 16'hDEAD;
      chk("valid", instr_valid, 1'b1);
      chk("instr", instr, vecs[i].rdata);
      chk("npc", npc, vecs[i].exp_npc);
      chk("req_drop", imem_req, 1'b0);
      for (int k = 0; k < vecs[i].rdy_lat; k++) begin
        step();
        chk("valid_hold", instr_valid, 1'b1);
        chk("instr_hold", instr, vecs[i].rdata);
        chk("npc_hold", npc, vecs[i].exp_npc);
        chk("req_low_valid", imem_req, 1'b0);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      br_pc       = vecs[i].br;
      step();
      instr_ready = 1'b0;
      br_pc       = 8'hAA;
      chk("valid_clr", instr_valid, 1'b0);
      chk("next_pc", pc, vecs[i].exp_next);
      chk("next_addr", imem_addr, vecs[i].exp_next);
`ifndef HAP_HALT_EN
      chk("halted_tied", halted, 1'b0);
`endif
      if (!vecs[i].en_acc) begin
        step();
        chk("idle_req", imem_req, 1'b0);
        step();
        chk("idle_req", imem_req, 1'b0);
        en = 1'b1;
      end
    end

`ifdef HAP_HALT_EN
    chk("halt_set", halted, 1'b1);
    chk("halt_pc", pc, 8'h04);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("halt_no_req", imem_req, 1'b0);
      chk("halt_stay", halted, 1'b1);
    end
`else
    chk("f800_req", imem_req, 1'b1);
    chk("f800_addr", imem_addr, 8'h04);
`endif

    // reset coinciding with an ack must discard the fetched word
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    rst_n = 1'b1;
    begin
      int n;
      n = 0;
      while (!imem_req && n < 10) begin
        step();
        n++;
      end
    end
    chk("rr_req", imem_req, 1'b1);
    chk("rr_addr", imem_addr, 8'h00);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1111;
    rst_n      = 1'b0;
    step();
    chk("rr_valid", instr_valid, 1'b0);
    chk("rr_pc", pc, 8'h00);
    chk("rr_instr", instr, 16'h0000);
    chk("rr_req_low", imem_req, 1'b0);
    chk("rr_halted", halted, 1'b0);
    imem_ack = 1'b0;
    en       = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_idle", imem_req, 1'b0);
    end
    en = 1'b1;
    step();
    chk("rr_restart_req", imem_req, 1'b1);
    chk("rr_restart_addr", imem_addr, 8'h00);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0800;
    step();
    imem_ack = 1'b0;
    chk("rr_fetch_valid", instr_valid, 1'b1);
    chk("rr_fetch_instr", instr, 16'h0800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
